// File: rtl/serv_mem_ctrl.sv
// Bit-serial load/store sequencer: operand shift-in, one bus transaction, result shift-out.
// Latency: WORDCYC init + bus wait + 1 + (loads only) WORDCYC run + 1 done cycle.
// Backpressure: the bus phase holds o_dbus_cyc until i_dbus_ack; new starts are ignored while busy.
module serv_mem_ctrl #(
    parameter int W = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_we,
    input  logic [1:0] i_size,
    input  logic       i_signed,
    input  logic [1:0] i_lsb,
    output logic       o_busy,
    output logic       o_init,
    output logic       o_byte_valid,
    output logic       o_load,
    output logic       o_rd_en,
    output logic       o_sext,
    output logic       o_dbus_cyc,
    output logic       o_dbus_we,
    output logic [3:0] o_dbus_sel,
    input  logic       i_dbus_ack,
    output logic       o_misalign,
    output logic       o_done
);

    localparam int WORDCYC = 32 / W;
    localparam logic [4:0] STEP = 5'(W);
    // Counter value in the final cycle of a shift phase; the next add wraps to 0.
    localparam logic [4:0] LAST = 5'((WORDCYC - 1) * W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_BUS,
        S_RUN,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic       we_q, we_d;
    logic [1:0] size_q, size_d;
    logic       signed_q, signed_d;
    logic [1:0] lsb_q, lsb_d;
    logic       misalign_q, misalign_d;
    logic       dbus_cyc_q, dbus_cyc_d;
    logic       dbus_we_q, dbus_we_d;
    logic [3:0] dbus_sel_q, dbus_sel_d;

    logic       phase_end;
    logic       misaligned;
    logic [1:0] byte_idx;
    logic       in_rd_window;
    logic [3:0] sel_pat;

    // The sign/zero choice for fill bits is made by the rd datapath; the
    // flag is still captured with the other operands so it stays stable.
    logic unused_signed;
    assign unused_signed = signed_q;

    assign phase_end  = (cnt_q == LAST);
    assign byte_idx   = cnt_q[4:3];
    assign misaligned = ((size_q == 2'd1) && lsb_q[0]) ||
                        (size_q[1] && (lsb_q != 2'd0));

    // Lane select and result window derived from latched size and address.
    always_comb begin
        sel_pat      = 4'b1111;
        in_rd_window = 1'b1;
        case (size_q)
            2'd0: begin
                sel_pat      = 4'b0001 << lsb_q;
                in_rd_window = (byte_idx == 2'd0);
            end
            2'd1: begin
                sel_pat      = 4'b0011 << lsb_q;
                in_rd_window = ~byte_idx[1];
            end
            default: begin
                sel_pat      = 4'b1111;
                in_rd_window = 1'b1;
            end
        endcase
    end

    // Next-state, operand capture, bit counter and registered bus request.
    always_comb begin
        state_d    = state_q;
        cnt_d      = 5'd0;
        we_d       = we_q;
        size_d     = size_q;
        signed_d   = signed_q;
        lsb_d      = lsb_q;
        misalign_d = misalign_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d    = S_INIT;
                    we_d       = i_we;
                    size_d     = i_size;
                    signed_d   = i_signed;
                    lsb_d      = i_lsb;
                    misalign_d = 1'b0;
                end
            end
            S_INIT: begin
                cnt_d = cnt_q + STEP;
                if (phase_end) begin
                    if (misaligned) begin
                        state_d    = S_DONE;
                        misalign_d = 1'b1;
                    end else begin
                        state_d = S_BUS;
                    end
                end
            end
            S_BUS: begin
                if (i_dbus_ack) begin
                    state_d = we_q ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + STEP;
                if (phase_end) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        dbus_cyc_d = (state_d == S_BUS);
        dbus_we_d  = (state_d == S_BUS) && we_d;
        dbus_sel_d = (state_d == S_BUS) ? sel_pat : 4'b0000;
    end

    // State, operand and bus-request registers; reset forces IDLE immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            we_q       <= 1'b0;
            size_q     <= 2'd0;
            signed_q   <= 1'b0;
            lsb_q      <= 2'd0;
            misalign_q <= 1'b0;
            dbus_cyc_q <= 1'b0;
            dbus_we_q  <= 1'b0;
            dbus_sel_q <= 4'b0000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            size_q     <= size_d;
            signed_q   <= signed_d;
            lsb_q      <= lsb_d;
            misalign_q <= misalign_d;
            dbus_cyc_q <= dbus_cyc_d;
            dbus_we_q  <= dbus_we_d;
            dbus_sel_q <= dbus_sel_d;
        end
    end

    // Phase strobes decoded from the registered state and counter.
    always_comb begin
        o_busy       = (state_q != S_IDLE);
        o_init       = (state_q == S_INIT);
        o_byte_valid = 1'b0;
        o_load       = 1'b0;
        o_rd_en      = 1'b0;
        o_sext       = 1'b0;
        o_done       = (state_q == S_DONE);
        case (state_q)
            S_INIT: o_byte_valid = (byte_idx >= lsb_q);
            S_BUS:  o_load       = i_dbus_ack && !we_q;
            S_RUN: begin
                o_byte_valid = 1'b1;
                o_rd_en      = in_rd_window;
                o_sext       = !in_rd_window;
            end
            default: ;
        endcase
    end

    assign o_dbus_cyc = dbus_cyc_q;
    assign o_dbus_we  = dbus_we_q;
    assign o_dbus_sel = dbus_sel_q;
    assign o_misalign = misalign_q;

endmodule

// File: tb/tb_serv_mem_ctrl.sv
module tb_serv_mem_ctrl;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_start;
    logic       i_we;
    logic [1:0] i_size;
    logic       i_signed;
    logic [1:0] i_lsb;
    logic       o_busy;
    logic       o_init;
    logic       o_byte_valid;
    logic       o_load;
    logic       o_rd_en;
    logic       o_sext;
    logic       o_dbus_cyc;
    logic       o_dbus_we;
    logic [3:0] o_dbus_sel;
    logic       i_dbus_ack;
    logic       o_misalign;
    logic       o_done;

    serv_mem_ctrl #(.W(1)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_we         (i_we),
        .i_size       (i_size),
        .i_signed     (i_signed),
        .i_lsb        (i_lsb),
        .o_busy       (o_busy),
        .o_init       (o_init),
        .o_byte_valid (o_byte_valid),
        .o_load       (o_load),
        .o_rd_en      (o_rd_en),
        .o_sext       (o_sext),
        .o_dbus_cyc   (o_dbus_cyc),
        .o_dbus_we    (o_dbus_we),
        .o_dbus_sel   (o_dbus_sel),
        .i_dbus_ack   (i_dbus_ack),
        .o_misalign   (o_misalign),
        .o_done       (o_done)
    );

    logic [14:0] all_outs;
    assign all_outs = {o_busy, o_init, o_byte_valid, o_load, o_rd_en, o_sext,
                       o_dbus_cyc, o_dbus_we, o_dbus_sel, o_misalign, o_done};

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Per-operation observations gathered by run_op.
    int         r_init, r_bv_init, r_first_bv, r_bv_run, r_cyc;
    int         r_load, r_rd, r_sext, r_done_at;
    logic [3:0] r_sel;
    logic       r_we, r_mis;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start_op(input logic we, input logic [1:0] size, input logic sgn,
                            input logic [1:0] lsb);
        i_we     = we;
        i_size   = size;
        i_signed = sgn;
        i_lsb    = lsb;
        i_start  = 1'b1;
        step();
        i_start  = 1'b0;
    endtask

    // Runs from the first INIT cycle until o_done, acking ack_wait cycles into BUS.
    // r_done_at counts clock edges from the start-accepting edge to DONE.
    task automatic run_op(input int ack_wait);
        int bus_i;
        int init_i;
        bit got;
        bus_i = 0; init_i = 0; got = 1'b0;
        r_init = 0; r_bv_init = 0; r_first_bv = -1; r_bv_run = 0; r_cyc = 0;
        r_load = 0; r_rd = 0; r_sext = 0; r_done_at = -1;
        r_sel = 4'b0000; r_we = 1'b0; r_mis = 1'b0;
        for (int e = 0; e < 300 && !got; e++) begin
            i_dbus_ack = o_dbus_cyc && (bus_i == ack_wait);
            #1;
            if (o_init) begin
                r_init++;
                if (o_byte_valid) begin
                    r_bv_init++;
                    if (r_first_bv < 0) r_first_bv = init_i;
                end
                init_i++;
            end else if (o_byte_valid) begin
                r_bv_run++;
            end
            if (o_dbus_cyc) begin
                r_cyc++;
                r_sel = r_sel | o_dbus_sel;
                r_we  = r_we | o_dbus_we;
                bus_i++;
            end
            if (o_load)  r_load++;
            if (o_rd_en) r_rd++;
            if (o_sext)  r_sext++;
            if (o_done) begin
                got       = 1'b1;
                r_done_at = e;
                r_mis     = o_misalign;
            end else begin
                step();
            end
        end
        i_dbus_ack = 1'b0;
        if (!got) chk("op_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        i_rst_n = 1'b0; i_start = 1'b0; i_we = 1'b0; i_size = 2'd0;
        i_signed = 1'b0; i_lsb = 2'd0; i_dbus_ack = 1'b0;

        // Reset state
        #3;
        chk("rst.outs", 32'(all_outs), 32'd0);
        step();
        chk("rst.outs_clk", 32'(all_outs), 32'd0);
        i_rst_n = 1'b1;

        // Word load, lsb 0, ack after 3 wait cycles
        start_op(1'b0, 2'd2, 1'b0, 2'd0);
        chk("ldw.init_first", 32'(o_init), 32'd1);
        run_op(3);
        chk("ldw.init_cycles", r_init, 32);
        chk("ldw.bv_init", r_bv_init, 32);
        chk("ldw.cyc_cycles", r_cyc, 4);
        chk("ldw.sel", 32'(r_sel), 32'hf);
        chk("ldw.we", 32'(r_we), 32'd0);
        chk("ldw.load", r_load, 1);
        chk("ldw.rd", r_rd, 32);
        chk("ldw.sext", r_sext, 0);
        chk("ldw.bv_run", r_bv_run, 32);
        chk("ldw.done_at", r_done_at, 68);
        step();
        chk("ldw.done_pulse", 32'(o_done), 32'd0);
        chk("ldw.idle", 32'(o_busy), 32'd0);

        // Signed byte load, lsb 2, ack after 1 wait cycle
        start_op(1'b0, 2'd0, 1'b1, 2'd2);
        run_op(1);
        chk("ldb.sel", 32'(r_sel), 32'h4);
        chk("ldb.first_bv", r_first_bv, 16);
        chk("ldb.bv_init", r_bv_init, 16);
        chk("ldb.rd", r_rd, 8);
        chk("ldb.sext", r_sext, 24);
        chk("ldb.load", r_load, 1);
        chk("ldb.done_at", r_done_at, 66);
        step();

        // Signed half load, lsb 2, ack in first bus cycle
        start_op(1'b0, 2'd1, 1'b1, 2'd2);
        run_op(0);
        chk("ldh.sel", 32'(r_sel), 32'hc);
        chk("ldh.rd", r_rd, 16);
        chk("ldh.sext", r_sext, 16);
        chk("ldh.done_at", r_done_at, 65);
        step();

        // Misaligned half store, lsb 1
        start_op(1'b1, 2'd1, 1'b0, 2'd1);
        run_op(0);
        chk("mis.cyc_cycles", r_cyc, 0);
        chk("mis.done_at", r_done_at, 32);
        chk("mis.flag_at_done", 32'(r_mis), 32'd1);
        step();
        step();
        step();
        chk("mis.flag_held", 32'(o_misalign), 32'd1);
        chk("mis.idle", 32'(o_busy), 32'd0);

        // Misaligned word load must also trap without a bus cycle
        start_op(1'b0, 2'd2, 1'b0, 2'd2);
        chk("misw.flag_cleared", 32'(o_misalign), 32'd0);
        run_op(0);
        chk("misw.cyc_cycles", r_cyc, 0);
        chk("misw.flag", 32'(r_mis), 32'd1);
        step();

        // Word store, ack in first bus cycle
        start_op(1'b1, 2'd2, 1'b0, 2'd0);
        chk("stw.flag_cleared", 32'(o_misalign), 32'd0);
        run_op(0);
        chk("stw.we", 32'(r_we), 32'd1);
        chk("stw.cyc_cycles", r_cyc, 1);
        chk("stw.load", r_load, 0);
        chk("stw.rd", r_rd, 0);
        chk("stw.bv_run", r_bv_run, 0);
        chk("stw.done_at", r_done_at, 33);
        chk("stw.mis", 32'(r_mis), 32'd0);
        step();

        // Asynchronous reset in the middle of a bus cycle
        start_op(1'b0, 2'd2, 1'b0, 2'd0);
        for (int k = 0; k < 40 && !o_dbus_cyc; k++) step();
        chk("arst.cyc_before", 32'(o_dbus_cyc), 32'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst.cyc_now", 32'(o_dbus_cyc), 32'd0);
        chk("arst.outs_now", 32'(all_outs), 32'd0);
        i_dbus_ack = 1'b1;
        step();
        step();
        chk("arst.outs_held", 32'(all_outs), 32'd0);
        i_rst_n = 1'b1;
        // stray ack still high while idle; start taken on the very next edge
        start_op(1'b0, 2'd0, 1'b0, 2'd3);
        chk("arst.start_next_edge", 32'(o_init), 32'd1);
        chk("arst.stray_ack_cyc", 32'(o_dbus_cyc), 32'd0);
        run_op(2);
        chk("arst.sel", 32'(r_sel), 32'h8);
        chk("arst.first_bv", r_first_bv, 24);
        chk("arst.rd", r_rd, 8);
        chk("arst.sext", r_sext, 24);
        chk("arst.done_at", r_done_at, 67);
        step();

        // Start held high for a whole load; operand changes mid-op are ignored
        i_we = 1'b0; i_size = 2'd2; i_signed = 1'b0; i_lsb = 2'd0;
        i_start = 1'b1;
        step();
        i_we = 1'b1; i_size = 2'd0; i_lsb = 2'd3;
        run_op(1);
        chk("hold.rd", r_rd, 32);
        chk("hold.sel", 32'(r_sel), 32'hf);
        chk("hold.we", 32'(r_we), 32'd0);
        chk("hold.done_at", r_done_at, 66);
        step();
        chk("hold.idle_after_done", 32'(o_busy), 32'd0);
        step();
        chk("hold.next_accepted", 32'(o_init), 32'd1);
        i_start = 1'b0;
        run_op(0);
        chk("hold2.we", 32'(r_we), 32'd1);
        chk("hold2.sel", 32'(r_sel), 32'h8);
        chk("hold2.done_at", r_done_at, 33);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serv_mem_ctrl.md
SERV_MEM_CTRL -- requirements
Module: serv_mem_ctrl

Interface
REQ-001 Parameter W, default 1, meaning data bits shifted per cycle; legal values 1, 2, 4.
REQ-002 Parameter WORDCYC, default 32/W, meaning cycles per 32-bit shift phase; derived, not overridden.
REQ-003 i_clk  in  1  sole clock, all state on rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i_start  in  1  request pulse; sampled only in IDLE.
REQ-006 i_we  in  1  1 = store, 0 = load; captured at start.
REQ-007 i_size  in  2  0 byte, 1 half, 2/3 word; captured at start.
REQ-008 i_signed  in  1  load sign-extension enable; captured at start.
REQ-009 i_lsb  in  2  address bits [1:0]; captured at start.
REQ-010 o_busy  out  1  high in any state other than IDLE.
REQ-011 o_init  out  1  high during INIT; the data buffer shifts operands in.
REQ-012 o_byte_valid  out  1  buffer shift enable qualifier.
REQ-013 o_load  out  1  one-cycle pulse; the buffer captures bus read data.
REQ-014 o_rd_en  out  1  load result bits valid toward rd.
REQ-015 o_sext  out  1  substitute fill bit (sign or zero) for rd.
REQ-016 o_dbus_cyc / o_dbus_we  out  1 / 1  bus request and write strobe.
REQ-017 o_dbus_sel  out  4  byte lane select.
REQ-018 i_dbus_ack  in  1  bus completion; meaningful only while o_dbus_cyc = 1.
REQ-019 o_misalign  out  1  trap flag, held from detection until the next accepted start.
REQ-020 o_done  out  1  one-cycle completion pulse.

Function
REQ-021 The FSM shall have states IDLE, INIT, BUS, RUN, DONE with a registered state.
REQ-022 Start acceptance: IDLE and i_start=1 -> INIT next cycle; operands are latched and o_misalign is cleared in the same edge.
REQ-023 i_start outside IDLE shall be ignored, with no effect on latched operands.
REQ-024 Bit counter cnt (5 bits) shall advance by W per cycle in INIT and RUN, clear on state entry, and wrap to 0 at the phase end; byte index = cnt[4:3].
REQ-025 INIT shall last exactly WORDCYC cycles; o_byte_valid = (byte index >= latched lsb) during INIT.
REQ-026 Misalignment: half with lsb[0]=1, or word with lsb!=0.
REQ-027 On misalignment, INIT -> DONE with o_misalign=1, and no bus cycle shall be issued.
REQ-028 When aligned, INIT -> BUS; o_dbus_cyc=1 is held through BUS, and o_dbus_we = latched i_we.
REQ-029 o_dbus_sel: byte = 4'b0001<<lsb; half = 4'b0011<<lsb; word = 4'b1111; 0 outside BUS.
REQ-030 BUS shall exit on the first cycle with i_dbus_ack=1: to DONE if store, to RUN if load with o_load=1 in that cycle; o_dbus_cyc drops next cycle.
REQ-031 BUS waits indefinitely; there is no timeout.
REQ-032 RUN shall last WORDCYC cycles, with o_byte_valid=1 throughout.
REQ-033 In RUN, o_rd_en=1 while byte index < size bytes (1, 2, 4); otherwise o_sext=1, and rd fill equals the sign bit only if i_signed, else zero.
REQ-034 DONE shall last one cycle with o_done=1, then -> IDLE; a start in the following IDLE cycle is accepted.
REQ-035 i_dbus_ack while o_dbus_cyc=0 shall be ignored.
REQ-036 o_dbus_* shall be registered, not combinational from i_dbus_ack.
REQ-037 Sequence lengths: load latency = WORDCYC + bus wait + 1 + WORDCYC + 1 cycles; store = WORDCYC + bus wait + 1 + 1 cycles.

Reset
REQ-038 Asserting i_rst_n=0 shall force IDLE immediately, independent of the clock, including mid-INIT, BUS or RUN.
REQ-039 During and after reset, all outputs shall be 0: o_busy, o_init, o_byte_valid, o_load, o_rd_en, o_sext, o_dbus_cyc, o_dbus_we, o_dbus_sel=0, o_misalign, o_done; cnt=0.
REQ-040 After deassertion, the first start shall be accepted on the next rising edge with no extra wait.

Verification (W=1)
REQ-041 Word load, lsb=0, ack 3 cycles after cyc -> sel=1111, o_load pulse once, o_rd_en for 32 RUN cycles, o_done at cycle 32+3+1+32+1.
REQ-042 Signed byte load, lsb=2 -> sel=0100, o_byte_valid=0 for INIT cycles 0-15, o_rd_en for 8 RUN cycles, o_sext for 24.
REQ-043 Half store, lsb=1 -> o_misalign=1, o_dbus_cyc never high, o_done 32 cycles after start, o_misalign held until the next start.
REQ-044 Word store, ack in first BUS cycle -> o_dbus_we=1, no o_load, no o_rd_en, o_done the following cycle.
REQ-045 Reset pulled low mid-BUS with cyc=1 -> o_dbus_cyc=0 without a clock edge; a later stray ack is ignored and a fresh start proceeds normally.
REQ-046 i_start held high throughout a load -> exactly one operation runs, and the next is accepted in the IDLE cycle after o_done.
